// File: rtl/mul_acc_ci.sv
// mul_acc_ci: command-driven multiply-accumulate unit.
//
// A 32x32 unsigned multiply is done shift-and-add, one multiplier bit per
// enabled clock. The low 32 bits of the product are then added into a 32-bit
// accumulator whose carry-out sets a sticky overflow flag. Other commands
// clear, read or load the accumulator in a single cycle.
//
// Ports:
//   clk        single clock, all state on rising edge
//   reset_n    asynchronous active-low reset
//   clk_en_i   global stall; when low every register holds
//   start_i    command strobe, sampled only in idle with clk_en_i high
//   n_i        opcode: 0 clear, 1 mac, 2 read, 3 load
//   dataa_i    operand A (unsigned) / load value
//   datab_i    operand B (unsigned)
//   result_o   command result, valid while done_o is high, held until next done
//   done_o     one enabled-cycle completion pulse per accepted command
//   busy_o     high while a mac is in progress
//   ovf_o      sticky accumulate carry-out flag
module mul_acc_ci (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en_i,
    input  logic        start_i,
    input  logic [1:0]  n_i,
    input  logic [31:0] dataa_i,
    input  logic [31:0] datab_i,
    output logic [31:0] result_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        ovf_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StAcc  = 2'd2
    } state_e;

    localparam logic [1:0] OpClear = 2'd0;
    localparam logic [1:0] OpMac   = 2'd1;
    localparam logic [1:0] OpRead  = 2'd2;
    localparam logic [1:0] OpLoad  = 2'd3;

    state_e      state_q;
    logic [31:0] acc_q;
    logic [31:0] prod_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [4:0]  count_q;
    logic [31:0] result_q;
    logic        done_q;
    logic        busy_q;
    logic        ovf_q;

    // 33-bit accumulate so the carry-out is visible for the overflow flag.
    logic [32:0] acc_sum;
    assign acc_sum = {1'b0, acc_q} + {1'b0, prod_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (clk_en_i) begin
            // done is a single enabled-cycle pulse unless set below.
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        case (n_i)
                            OpClear: begin
                                acc_q    <= '0;
                                ovf_q    <= 1'b0;
                                result_q <= '0;
                                done_q   <= 1'b1;
                            end
                            OpMac: begin
                                mcand_q  <= dataa_i;
                                mplier_q <= datab_i;
                                prod_q   <= '0;
                                count_q  <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= StMul;
                            end
                            OpRead: begin
                                result_q <= acc_q;
                                done_q   <= 1'b1;
                            end
                            OpLoad: begin
                                acc_q    <= dataa_i;
                                ovf_q    <= 1'b0;
                                result_q <= dataa_i;
                                done_q   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    // Product bits above 31 are dropped by the 32-bit add.
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 5'd1;
                    // Always 32 iterations; no early exit on a zero multiplier.
                    if (count_q == 5'd31) begin
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    acc_q    <= acc_sum[31:0];
                    ovf_q    <= ovf_q | acc_sum[32];
                    result_q <= acc_sum[31:0];
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_mul_acc_ci.sv
// tb_mul_acc_ci: directed self-checking bench for mul_acc_ci.
module tb_mul_acc_ci;

    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        ovf;

    int passed = 0;
    int total  = 0;

    mul_acc_ci dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en_i (clk_en),
        .start_i  (start),
        .n_i      (n),
        .dataa_i  (dataa),
        .datab_i  (datab),
        .result_o (result),
        .done_o   (done),
        .busy_o   (busy),
        .ovf_o    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one command and wait (bounded) for done; lat = enabled cycles
    // from start cycle to done, 0 on timeout.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cyc);
        start = 1'b1;
        n     = op;
        dataa = a;
        datab = b;
        lat      = 0;
        busy_cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int bcyc;
    int done_seen;

    initial begin
        reset_n = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        n       = 2'd0;
        dataa   = '0;
        datab   = '0;
        #1;
        check("rst_result", result, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Read after reset
        do_cmd(2'd2, 32'd0, 32'd0, lat, bcyc);
        check("read0_lat", lat, 32'd1);
        check("read0_result", result, 32'd0);
        check("read0_ovf", {31'd0, ovf}, 32'd0);
        tick();
        check("read0_done_drop", {31'd0, done}, 32'd0);

        // Clear, then two accumulating macs
        do_cmd(2'd0, 32'd0, 32'd0, lat, bcyc);
        check("clr_lat", lat, 32'd1);
        do_cmd(2'd1, 32'd1, 32'd2, lat, bcyc);
        check("mac1_lat", lat, 32'd34);
        check("mac1_busy", bcyc, 32'd33);
        check("mac1_result", result, 32'd2);
        check("mac1_busy_at_done", {31'd0, busy}, 32'd0);
        tick();
        check("mac1_done_drop", {31'd0, done}, 32'd0);
        check("mac1_result_hold", result, 32'd2);
        do_cmd(2'd1, 32'd332, 32'd22, lat, bcyc);
        check("mac2_lat", lat, 32'd34);
        check("mac2_busy", bcyc, 32'd33);
        check("mac2_result", result, 32'd7306);

        // Load near the top, overflow on accumulate
        do_cmd(2'd3, 32'hFFFF_FFF0, 32'd0, lat, bcyc);
        check("load_result", result, 32'hFFFF_FFF0);
        check("load_ovf", {31'd0, ovf}, 32'd0);
        do_cmd(2'd1, 32'd2, 32'd23, lat, bcyc);
        check("ovf_mac_result", result, 32'h0000_001E);
        check("ovf_mac_ovf", {31'd0, ovf}, 32'd1);
        do_cmd(2'd2, 32'd0, 32'd0, lat, bcyc);
        check("ovf_read_result", result, 32'h0000_001E);
        check("ovf_read_sticky", {31'd0, ovf}, 32'd1);
        do_cmd(2'd0, 32'd0, 32'd0, lat, bcyc);
        check("clr_ovf", {31'd0, ovf}, 32'd0);
        check("clr_result", result, 32'd0);

        // Truncated product: 2^16 * 2^16 wraps to 0, no overflow
        do_cmd(2'd1, 32'h0001_0000, 32'h0001_0000, lat, bcyc);
        check("trunc_lat", lat, 32'd34);
        check("trunc_result", result, 32'd0);
        check("trunc_ovf", {31'd0, ovf}, 32'd0);

        // Stall for 5 cycles mid-mul plus an ignored start while busy
        start = 1'b1;
        n     = 2'd1;
        dataa = 32'd2;
        datab = 32'd23;
        lat       = 0;
        done_seen = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            start = 1'b0;
            if (done) begin
                done_seen++;
                if (lat == 0) lat = i;
            end
            if (i == 5) clk_en = 1'b0;
            if (i == 10) clk_en = 1'b1;
            if (i == 14) begin
                start = 1'b1;
                n     = 2'd0;
            end
            if (lat != 0) break;
        end
        check("stall_lat", lat, 32'd39);
        check("stall_result", result, 32'd46);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("stall_single_done", done_seen, 32'd1);
        check("stall_result_hold", result, 32'd46);

        // done holds while stalled, drops on the next enabled cycle
        do_cmd(2'd2, 32'd0, 32'd0, lat, bcyc);
        check("hold_read", result, 32'd46);
        clk_en = 1'b0;
        tick();
        tick();
        check("hold_done_stalled", {31'd0, done}, 32'd1);
        clk_en = 1'b1;
        tick();
        check("hold_done_drop", {31'd0, done}, 32'd0);

        // Reset mid-mac aborts with no done pulse
        do_cmd(2'd0, 32'd0, 32'd0, lat, bcyc);
        start = 1'b1;
        n     = 2'd1;
        dataa = 32'd7;
        datab = 32'd9;
        done_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            start = 1'b0;
            if (done) done_seen++;
        end
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        do_cmd(2'd1, 32'd3, 32'd5, lat, bcyc);
        check("post_rst_lat", lat, 32'd34);
        check("post_rst_result", result, 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_acc_ci.md
MUL_ACC_CI -- requirements
Module: mul_acc_ci

Interface
REQ-001 Parameter: none; all widths fixed at 32 bits (operands, product, accumulator).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 clk_en  input  1  global stall: when 0, all internal state and outputs hold.
REQ-005 start  input  1  command strobe, one cycle, sampled only in IDLE with clk_en=1.
REQ-006 n  input  2  opcode: 0=CLEAR, 1=MAC, 2=READ, 3=LOAD.
REQ-007 dataa  input  32  operand A, unsigned; LOAD value.
REQ-008 datab  input  32  operand B, unsigned.
REQ-009 result  output  32  command result, valid while done=1, held until next done.
REQ-010 done  output  1  one-cycle completion pulse per accepted command.
REQ-011 busy  output  1  high while a MAC is in progress (states MUL, ACC).
REQ-012 ovf  output  1  sticky accumulate carry-out flag.

Function
REQ-013 States SHALL be IDLE, MUL, ACC; reset state IDLE.
REQ-014 IDLE + start + clk_en + n=0: acc<=0, ovf<=0, result<=0, done=1 next cycle, stay IDLE.
REQ-015 IDLE + start + clk_en + n=2: result<=acc, done=1 next cycle, acc/ovf unchanged.
REQ-016 IDLE + start + clk_en + n=3: acc<=dataa, ovf<=0, result<=dataa, done=1 next cycle.
REQ-017 IDLE + start + clk_en + n=1: latch mcand<=dataa, mplier<=datab, prod<=0, count<=0, go MUL.
REQ-018 MUL, each clk_en edge: if mplier[0] then prod<=prod+mcand (mod 2^32); mcand<<=1; mplier>>=1; count++.
REQ-019 MUL SHALL run exactly 32 iterations (no early exit); after the 32nd go ACC.
REQ-020 ACC, one clk_en edge: {carry,acc}<=acc+prod; ovf<=ovf|carry; result<=new acc; done=1 next cycle; go IDLE.
REQ-021 MAC latency: done high in the 34th clk_en-enabled cycle after the start cycle (start cycle = 0).
REQ-022 Product is the low 32 bits of dataa*datab; high bits discarded, never set ovf.
REQ-023 start while busy=1 SHALL be ignored (no queuing, no state change).
REQ-024 start with clk_en=0 SHALL be ignored.
REQ-025 done SHALL be 1 for exactly one clk_en-enabled cycle, then 0; with clk_en=0 done holds its value.
REQ-026 busy SHALL rise the cycle after an accepted MAC start and fall in the same cycle done rises.
REQ-027 result SHALL only change on the edge that sets done.

Reset
REQ-028 reset_n=0 SHALL immediately force: state=IDLE, acc=0, prod=0, count=0, result=0, done=0, busy=0, ovf=0.
REQ-029 reset_n asserted mid-MAC SHALL abort the MAC with no done pulse; first start after release is accepted normally.

Verification
REQ-030 Reset, start n=2 -> done=1 next cycle, result=0, ovf=0.
REQ-031 CLEAR; MAC 1,2; MAC 332,22 -> first done result=2, second result=7306, each done 34 cycles after its start, busy high 33 cycles.
REQ-032 LOAD 0xFFFFFFF0; MAC 2,23 -> result=0x0000001E, ovf=1; READ -> result 0x1E, ovf still 1; CLEAR -> ovf=0.
REQ-033 MAC 0x00010000,0x00010000 after CLEAR -> result=0, ovf=0 (truncated product).
REQ-034 MAC 2,23 with clk_en=0 for 5 cycles mid-MUL, plus start pulse while busy -> single done at cycle 39, result=46.
REQ-035 reset_n low at cycle 10 of a MAC -> done never pulses, all outputs 0; then MAC 3,5 -> result=15.
